apb_master_arbiter: RTL and testbench



---
 rtl/apb_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 20 ++
 rtl/apb_master_arbiter.sv | 143 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the two-master APB3 arbiter: FSM state
// encoding, slot geometry and the PADDR slot-to-PSEL decode.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int NSLOTS = 16;
   localparam int SLOT_W = 4;

   function automatic logic [NSLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
      logic [NSLOTS-1:0] oh;
      oh       = '0;
      oh[slot] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. sel_o = 1 selects M1; on a tie the master
// that was not granted last (last_i) wins.
module rr_arb2 (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic valid_o,
   output logic sel_o
);

   always_comb begin
      valid_o = req0_i | req1_i;
      if (req0_i && req1_i) begin
         sel_o = ~last_i;
      end else begin
         sel_o = req1_i & ~req0_i;
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-master APB3 arbiter and transfer sequencer: round-robin grant,
// SETUP/ACCESS sequencing, one-hot slot select and a per-transfer timeout.
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int SLOT_MSB = 27,
   parameter int TIMEOUT  = 256
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        M0_REQ,
   input  logic [31:0] M0_ADDR,
   input  logic        M0_WRITE,
   input  logic [31:0] M0_WDATA,
   output logic        M0_ACK,
   output logic [31:0] M0_RDATA,
   output logic        M0_ERR,
   input  logic        M1_REQ,
   input  logic [31:0] M1_ADDR,
   input  logic        M1_WRITE,
   input  logic [31:0] M1_WDATA,
   output logic        M1_ACK,
   output logic [31:0] M1_RDATA,
   output logic        M1_ERR,
   output logic [31:0] PADDR,
   output logic [15:0] PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PWDATA,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   // The counter only has to reach TIMEOUT-1: the final ACCESS cycle is
   // the one in which the count already equals that value.
   localparam int              CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam bit              TO_EN   = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t             state_q;
   logic               gnt_q;
   logic               last_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [31:0]        paddr_q;
   logic [NSLOTS-1:0]  psel_q;
   logic               penable_q;
   logic               pwrite_q;
   logic [31:0]        pwdata_q;
   logic [1:0]         ack_q;
   logic [1:0]         err_q;
   logic [1:0][31:0]   rdata_q;

   logic               arb_valid;
   logic               arb_sel;
   logic [31:0]        win_addr;
   logic               win_write;
   logic [31:0]        win_wdata;
   logic               xfer_end;

   rr_arb2 u_rr_arb2 (
      .req0_i  (M0_REQ),
      .req1_i  (M1_REQ),
      .last_i  (last_q),
      .valid_o (arb_valid),
      .sel_o   (arb_sel)
   );

   always_comb begin
      win_addr  = arb_sel ? M1_ADDR  : M0_ADDR;
      win_write = arb_sel ? M1_WRITE : M0_WRITE;
      win_wdata = arb_sel ? M1_WDATA : M0_WDATA;
      xfer_end  = PREADY || (TO_EN && (cnt_q == TO_LAST));
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= ST_IDLE;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         paddr_q   <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         ack_q     <= '0;
         err_q     <= '0;
         rdata_q   <= '0;
      end else begin
         // ACK/ERR are single-cycle strobes; RDATA is left to hold.
         ack_q <= '0;
         err_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (arb_valid) begin
                  gnt_q    <= arb_sel;
                  paddr_q  <= win_addr;
                  pwrite_q <= win_write;
                  pwdata_q <= win_wdata;
                  psel_q   <= slot_onehot(win_addr[SLOT_MSB -: SLOT_W]);
                  state_q  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               cnt_q     <= '0;
               state_q   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (xfer_end) begin
                  psel_q         <= '0;
                  penable_q      <= 1'b0;
                  ack_q[gnt_q]   <= 1'b1;
                  err_q[gnt_q]   <= PREADY ? PSLVERR : 1'b1;
                  rdata_q[gnt_q] <= (PREADY && !pwrite_q && !PSLVERR) ? PRDATA : 32'h0;
                  state_q        <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               last_q  <= gnt_q;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign PADDR    = paddr_q;
   assign PSEL     = psel_q;
   assign PENABLE  = penable_q;
   assign PWRITE   = pwrite_q;
   assign PWDATA   = pwdata_q;
   assign M0_ACK   = ack_q[0];
   assign M1_ACK   = ack_q[1];
   assign M0_ERR   = err_q[0];
   assign M1_ERR   = err_q[1];
   assign M0_RDATA = rdata_q[0];
   assign M1_RDATA = rdata_q[1];

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter with a small APB
// slave model (configurable wait states, stuck-not-ready, PSLVERR).
module tb_apb_master_arbiter;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        M0_REQ, M0_WRITE, M1_REQ, M1_WRITE;
   logic [31:0] M0_ADDR, M0_WDATA, M1_ADDR, M1_WDATA;
   logic        M0_ACK, M0_ERR, M1_ACK, M1_ERR;
   logic [31:0] M0_RDATA, M1_RDATA;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic [15:0] PSEL;
   logic        PENABLE, PWRITE, PSLVERR;
   wire         PREADY;

   int n_checks = 0;
   int n_pass   = 0;

   // slave model: ready on the (wait_cfg+1)-th ACCESS cycle unless stuck
   int wait_cfg = 0;
   bit stuck    = 1'b0;
   int acc_cnt  = 0;

   int cyc, pen, who;
   logic [15:0] psel1;
   logic        pen1;
   int ack_who[4];
   int ack_cyc[4];
   int na;

   always #5 PCLK = ~PCLK;

   always @(posedge PCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;
   assign PREADY = PENABLE && !stuck && (acc_cnt >= wait_cfg);

   apb_master_arbiter #(.SLOT_MSB(27), .TIMEOUT(8)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .M0_REQ(M0_REQ), .M0_ADDR(M0_ADDR), .M0_WRITE(M0_WRITE), .M0_WDATA(M0_WDATA),
      .M0_ACK(M0_ACK), .M0_RDATA(M0_RDATA), .M0_ERR(M0_ERR),
      .M1_REQ(M1_REQ), .M1_ADDR(M1_ADDR), .M1_WRITE(M1_WRITE), .M1_WDATA(M1_WDATA),
      .M1_ACK(M1_ACK), .M1_RDATA(M1_RDATA), .M1_ERR(M1_ERR),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge PCLK);
      #1;
   endtask

   // Ticks until an ACK is seen (or the limit expires, leaving who = -1).
   task automatic run_until_ack(input int limit, output int c, output int p, output int w,
                                output logic [15:0] ps1, output logic pe1);
      c = 0; p = 0; w = -1; ps1 = '0; pe1 = 1'b0;
      for (int i = 0; i < limit && w < 0; i++) begin
         tick;
         c++;
         if (i == 0) begin
            ps1 = PSEL;
            pe1 = PENABLE;
         end
         if (PENABLE) p++;
         if (M0_ACK || M1_ACK) w = (M0_ACK && M1_ACK) ? 2 : (M1_ACK ? 1 : 0);
      end
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_psel"},     32'(PSEL),     32'h0);
      check({pfx, "_penable"},  32'(PENABLE),  32'h0);
      check({pfx, "_paddr"},    PADDR,         32'h0);
      check({pfx, "_pwrite"},   32'(PWRITE),   32'h0);
      check({pfx, "_pwdata"},   PWDATA,        32'h0);
      check({pfx, "_m0_ack"},   32'(M0_ACK),   32'h0);
      check({pfx, "_m1_ack"},   32'(M1_ACK),   32'h0);
      check({pfx, "_m0_err"},   32'(M0_ERR),   32'h0);
      check({pfx, "_m1_err"},   32'(M1_ERR),   32'h0);
      check({pfx, "_m0_rdata"}, M0_RDATA,      32'h0);
      check({pfx, "_m1_rdata"}, M1_RDATA,      32'h0);
   endtask

   initial begin
      PRESET = 1'b1;
      M0_REQ = 1'b0; M0_WRITE = 1'b0; M0_ADDR = '0; M0_WDATA = '0;
      M1_REQ = 1'b0; M1_WRITE = 1'b0; M1_ADDR = '0; M1_WDATA = '0;
      PRDATA = '0; PSLVERR = 1'b0;
      tick; tick;
      check_reset_values("rst");
      PRESET = 1'b0;
      tick;

      // T1: M0 write, zero-wait slave, checked cycle by cycle
      M0_ADDR = 32'h0300_0010; M0_WRITE = 1'b1; M0_WDATA = 32'hA5A5_5A5A; M0_REQ = 1'b1;
      tick;
      check("t1_setup_psel",    32'(PSEL),    32'h0008);
      check("t1_setup_penable", 32'(PENABLE), 32'h0);
      check("t1_setup_paddr",   PADDR,        32'h0300_0010);
      check("t1_setup_pwrite",  32'(PWRITE),  32'h1);
      check("t1_setup_pwdata",  PWDATA,       32'hA5A5_5A5A);
      tick;
      check("t1_access_psel",    32'(PSEL),    32'h0008);
      check("t1_access_penable", 32'(PENABLE), 32'h1);
      tick;
      check("t1_m0_ack",   32'(M0_ACK), 32'h1);
      check("t1_m1_ack",   32'(M1_ACK), 32'h0);
      check("t1_m0_err",   32'(M0_ERR), 32'h0);
      check("t1_m0_rdata", M0_RDATA,    32'h0);
      check("t1_psel_drop", 32'(PSEL),  32'h0);
      $display("xfer T1: M0 write addr=%08h data=%08h ack err=%0d", M0_ADDR, M0_WDATA, M0_ERR);
      M0_REQ = 1'b0;
      tick;
      check("t1_ack_pulse", 32'(M0_ACK), 32'h0);

      // T2: M1 read with 3 wait states
      wait_cfg = 3; PRDATA = 32'h1234_5678;
      M1_ADDR = 32'h0F00_0004; M1_WRITE = 1'b0; M1_REQ = 1'b1;
      run_until_ack(20, cyc, pen, who, psel1, pen1);
      check("t2_who",        who,          1);
      check("t2_ack_cycle",  cyc,          6);
      check("t2_pen_cycles", pen,          4);
      check("t2_setup_psel", 32'(psel1),   32'h8000);
      check("t2_setup_pen",  32'(pen1),    32'h0);
      check("t2_m1_rdata",   M1_RDATA,     32'h1234_5678);
      check("t2_m1_err",     32'(M1_ERR),  32'h0);
      check("t2_m0_ack",     32'(M0_ACK),  32'h0);
      $display("xfer T2: M1 read addr=%08h rdata=%08h after %0d cycles", M1_ADDR, M1_RDATA, cyc);
      M1_REQ = 1'b0; wait_cfg = 0;
      tick;

      // T3: both requesting continuously, expect strict alternation
      M0_ADDR = 32'h0100_0000; M0_WRITE = 1'b1; M0_WDATA = 32'h1111_1111;
      M1_ADDR = 32'h0200_0008; M1_WRITE = 1'b0; PRDATA = 32'hCAFE_0001;
      M0_REQ = 1'b1; M1_REQ = 1'b1;
      na = 0;
      for (int c = 1; c <= 15; c++) begin
         tick;
         if (M0_ACK || M1_ACK) begin
            if (na < 4) begin
               ack_who[na] = M1_ACK ? 1 : 0;
               ack_cyc[na] = c;
               if (M1_ACK) check("t3_m1_rdata", M1_RDATA, 32'hCAFE_0001);
               $display("xfer T3.%0d: M%0d ack at cycle %0d", na, ack_who[na], c);
            end
            na++;
         end
      end
      check("t3_ack_count", na, 4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("t3_who%0d", k), ack_who[k], k % 2);
         check($sformatf("t3_cyc%0d", k), ack_cyc[k], 3 + 4 * k);
      end
      M0_REQ = 1'b0; M1_REQ = 1'b0;
      tick; tick;
      check("t3_idle_psel", 32'(PSEL), 32'h0);

      // T4: read with PSLVERR
      M0_ADDR = 32'h0500_0020; M0_WRITE = 1'b0; PRDATA = 32'hDEAD_BEEF; PSLVERR = 1'b1;
      M0_REQ = 1'b1;
      run_until_ack(20, cyc, pen, who, psel1, pen1);
      check("t4_who",       who,          0);
      check("t4_ack_cycle", cyc,          3);
      check("t4_m0_err",    32'(M0_ERR),  32'h1);
      check("t4_m0_rdata",  M0_RDATA,     32'h0);
      check("t4_m1_rdata_hold", M1_RDATA, 32'hCAFE_0001);
      check("t4_m1_err",    32'(M1_ERR),  32'h0);
      $display("xfer T4: M0 read addr=%08h err=%0d rdata=%08h", M0_ADDR, M0_ERR, M0_RDATA);
      M0_REQ = 1'b0; PSLVERR = 1'b0;
      tick;

      // T5: slave never ready, timeout after 8 ACCESS cycles
      stuck = 1'b1; PRDATA = 32'h5555_AAAA;
      M1_ADDR = 32'h0A00_0000; M1_WRITE = 1'b0; M1_REQ = 1'b1;
      run_until_ack(30, cyc, pen, who, psel1, pen1);
      check("t5_who",        who,           1);
      check("t5_ack_cycle",  cyc,           10);
      check("t5_pen_cycles", pen,           8);
      check("t5_m1_err",     32'(M1_ERR),   32'h1);
      check("t5_m1_rdata",   M1_RDATA,      32'h0);
      check("t5_psel",       32'(PSEL),     32'h0);
      check("t5_penable",    32'(PENABLE),  32'h0);
      $display("xfer T5: M1 read addr=%08h timeout err=%0d after %0d cycles", M1_ADDR, M1_ERR, cyc);
      M1_REQ = 1'b0; stuck = 1'b0;
      tick;

      // T6: make M0 the last grant, then reset during an M1 ACCESS
      M0_ADDR = 32'h0000_0000; M0_WRITE = 1'b1; M0_WDATA = 32'h0000_0042; M0_REQ = 1'b1;
      run_until_ack(20, cyc, pen, who, psel1, pen1);
      check("t6_pre_who", who, 0);
      $display("xfer T6a: M0 write addr=%08h ack", M0_ADDR);
      M0_REQ = 1'b0;
      tick;
      stuck = 1'b1;
      M1_ADDR = 32'h0600_0000; M1_WRITE = 1'b1; M1_WDATA = 32'h0000_0099; M1_REQ = 1'b1;
      tick; tick; tick;
      check("t6_in_access", 32'(PENABLE), 32'h1);
      PRESET = 1'b1;
      tick;
      check_reset_values("t6_rst");
      $display("xfer T6b: M1 write addr=%08h aborted by reset", M1_ADDR);
      PRESET = 1'b0; stuck = 1'b0;
      M0_ADDR = 32'h0700_0000; M0_WRITE = 1'b1; M0_WDATA = 32'h0000_0077; M0_REQ = 1'b1;
      run_until_ack(20, cyc, pen, who, psel1, pen1);
      check("t6_tie_who",   who,        0);
      check("t6_ack_cycle", cyc,        3);
      check("t6_psel",      32'(psel1), 32'h0080);
      $display("xfer T6c: tie after reset granted M%0d", who);
      M0_REQ = 1'b0; M1_REQ = 1'b0;
      tick; tick;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
